dsm_decimation_chain: RTL and testbench

Converts a 1-bit delta-sigma modulator bitstream into 24-bit signed PCM by a total decimation of 64. Stages: a 4-stage CIC decimator (R=32), then a 7-tap half-band FIR decimator (R=2). The block sits between the DSM front end and the PCM consumer. It runs on the fast system clock (100 MHz) and advances only on `dsm_en` strobes (nominally 81 920 Hz), giving PCM at 1 280 Hz.

---
 rtl/dsm_decimation_chain.sv | 119 +++++++++++
 tb/tb_dsm_decimation_chain.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_decimation_chain.sv
`default_nettype none
// ============================================================================
// dsm_decimation_chain : 1-bit DSM stream -> 24-bit PCM, CIC4 (R=32) + HB FIR (R=2)
// Revision: 1.0
// ============================================================================
module dsm_decimation_chain (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dsm_in,
    input  logic        dsm_en,
    output logic [23:0] pcm_out,
    output logic        pcm_valid
);

    localparam int N_STAGES = 4;
    localparam int N_TAPS   = 7;

    logic signed [23:0] integ_q [N_STAGES];
    logic signed [23:0] integ_d [N_STAGES];
    logic signed [23:0] comb_dly_q [N_STAGES];
    logic signed [23:0] comb_diff [N_STAGES];
    logic signed [23:0] tap_q [N_TAPS];
    logic signed [23:0] y_q;
    logic signed [23:0] x_in;
    logic [4:0]         cnt_q;
    logic               dec_q;
    logic               y_vld_q;
    logic               phase_q;
    logic               fir_go_q;

    logic signed [27:0] e0, e2, e3, e4, e6;
    logic signed [27:0] acc;
    logic signed [27:0] acc_sh;
    logic [23:0]        pcm_sat;

    // Integrators chain combinationally within one strobe, so no extra sample delay.
    always_comb begin
        x_in       = dsm_in ? 24'sd1 : -24'sd1;
        integ_d[0] = integ_q[0] + x_in;
        for (int i = 1; i < N_STAGES; i++) begin
            integ_d[i] = integ_q[i] + integ_d[i-1];
        end
        comb_diff[0] = integ_q[N_STAGES-1] - comb_dly_q[0];
        for (int i = 1; i < N_STAGES; i++) begin
            comb_diff[i] = comb_diff[i-1] - comb_dly_q[i];
        end
    end

    always_comb begin
        e0     = {{4{tap_q[0][23]}}, tap_q[0]};
        e2     = {{4{tap_q[2][23]}}, tap_q[2]};
        e3     = {{4{tap_q[3][23]}}, tap_q[3]};
        e4     = {{4{tap_q[4][23]}}, tap_q[4]};
        e6     = {{4{tap_q[6][23]}}, tap_q[6]};
        acc    = (e2 <<< 3) + e2 + (e3 <<< 4) + (e4 <<< 3) + e4 - e0 - e6;
        acc_sh = acc >>> 2;
        // In range only when the bits above the 24-bit sign are pure sign extension.
        if (acc_sh[27:23] == 5'b00000 || acc_sh[27:23] == 5'b11111) begin
            pcm_sat = acc_sh[23:0];
        end else if (acc_sh[27]) begin
            pcm_sat = 24'h800000;
        end else begin
            pcm_sat = 24'h7FFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                integ_q[i]    <= '0;
                comb_dly_q[i] <= '0;
            end
            for (int i = 0; i < N_TAPS; i++) begin
                tap_q[i] <= '0;
            end
            cnt_q     <= '0;
            dec_q     <= 1'b0;
            y_q       <= '0;
            y_vld_q   <= 1'b0;
            phase_q   <= 1'b0;
            fir_go_q  <= 1'b0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            dec_q <= dsm_en && (cnt_q == 5'd31);
            if (dsm_en) begin
                cnt_q <= cnt_q + 5'd1;
                for (int i = 0; i < N_STAGES; i++) begin
                    integ_q[i] <= integ_d[i];
                end
            end

            y_vld_q <= dec_q;
            if (dec_q) begin
                comb_dly_q[0] <= integ_q[N_STAGES-1];
                for (int i = 1; i < N_STAGES; i++) begin
                    comb_dly_q[i] <= comb_diff[i-1];
                end
                y_q <= comb_diff[N_STAGES-1];
            end

            fir_go_q <= y_vld_q && phase_q;
            if (y_vld_q) begin
                tap_q[0] <= y_q;
                for (int i = 1; i < N_TAPS; i++) begin
                    tap_q[i] <= tap_q[i-1];
                end
                phase_q <= ~phase_q;
            end

            pcm_valid <= fir_go_q;
            if (fir_go_q) begin
                pcm_out <= pcm_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsm_decimation_chain.sv
`default_nettype none
// Bench for dsm_decimation_chain: random and directed bitstreams against a
// convolution-level model of the CIC + half-band chain.
module tb_dsm_decimation_chain;

    logic        clk;
    logic        rst_n;
    logic        dsm_in;
    logic        dsm_en;
    logic [23:0] pcm_out;
    logic        pcm_valid;

    dsm_decimation_chain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dsm_in    (dsm_in),
        .dsm_en    (dsm_en),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint due;
        int     val;
    } exp_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc   = 0;
    bit     armed = 0;
    bit     exp_vld = 0;
    int     exp_hold = 0;
    int     h [0:124];
    int     hist [$];
    int     ys [$];
    exp_t   expq [$];

    int     pulses = 0;
    longint first_cyc = -1;
    longint last_cyc = -1;
    int     got [$];
    int     fresh [0:1];

    function automatic void chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    // CIC impulse response = four cascaded length-32 boxcars.
    initial begin
        int t [0:124];
        int s;
        for (int k = 0; k < 125; k++) h[k] = (k < 32) ? 1 : 0;
        repeat (3) begin
            for (int k = 0; k < 125; k++) begin
                s = 0;
                for (int j = 0; j < 32; j++) if (k - j >= 0) s += h[k-j];
                t[k] = s;
            end
            h = t;
        end
    end

    // Reference model: sampled at each rising edge with the same inputs the DUT sees.
    initial begin
        int     y, acc, sh, pcm, n, m;
        exp_t   e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                hist.delete();
                ys.delete();
                expq.delete();
                exp_vld  = 0;
                exp_hold = 0;
                armed    = 1;
            end else begin
                exp_vld = 0;
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    e = expq.pop_front();
                    exp_vld  = 1;
                    exp_hold = e.val;
                end
                if (dsm_en) begin
                    hist.push_back(dsm_in ? 1 : -1);
                    if (hist.size() % 32 == 0) begin
                        n = hist.size() - 1;
                        y = 0;
                        for (int k = 0; k < 125; k++) if (n - k >= 0) y += h[k] * hist[n-k];
                        ys.push_back(y);
                        if (ys.size() % 2 == 0) begin
                            m   = ys.size() - 1;
                            acc = -ys[m];
                            if (m >= 2) acc += 9 * ys[m-2];
                            if (m >= 3) acc += 16 * ys[m-3];
                            if (m >= 4) acc += 9 * ys[m-4];
                            if (m >= 6) acc -= ys[m-6];
                            sh  = acc >>> 2;
                            pcm = (sh > 8388607) ? 8388607 : (sh < -8388608) ? -8388608 : sh;
                            e.due = cyc + 3;
                            e.val = pcm;
                            expq.push_back(e);
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                if (exp_vld) begin
                    chk("pcm_valid_pulse", pcm_valid, 1);
                    chk("pcm_out_value", $signed(pcm_out), exp_hold);
                end else begin
                    chk("pcm_valid_idle", pcm_valid, 0);
                    chk("pcm_out_hold", $signed(pcm_out), exp_hold);
                end
                if (pcm_valid) begin
                    pulses++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    got.push_back($signed(pcm_out));
                end
            end
        end
    end

    task automatic clr_stats();
        pulses    = 0;
        first_cyc = -1;
        last_cyc  = -1;
        got.delete();
    endtask

    // Called at a falling edge; returns the index of the rising edge that took the strobe.
    task automatic drive(input bit b, input int gap, output longint sc);
        dsm_en = 1'b1;
        dsm_in = b;
        @(negedge clk);
        sc     = cyc;
        dsm_en = 1'b0;
        dsm_in = 1'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            dsm_en = 1'(i % 2);
            dsm_in = 1'b1;
            @(negedge clk);
        end
        dsm_en = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        longint sc, s64;
        int hsum;
        rst_n  = 1'b0;
        dsm_en = 1'b0;
        dsm_in = 1'b0;
        @(negedge clk);

        hsum = 0;
        for (int k = 0; k < 125; k++) hsum += h[k];
        chk("model_cic_gain", hsum, 1048576);

        do_reset(10);
        chk("reset_pcm_out", $signed(pcm_out), 0);
        chk("reset_pcm_valid", pcm_valid, 0);

        // All-ones, evenly spaced strobes
        clr_stats();
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, 19, sc);
            if (i == 63) s64 = sc;
        end
        repeat (10) @(negedge clk);
        chk("ones_first_latency", first_cyc, s64 + 3);
        chk("ones_pulse_count", pulses, 16);
        chk("ones_pulse_span", last_cyc - first_cyc, 15 * 64 * 20);
        if (got.size() == 16) begin
            for (int i = 8; i < 16; i++) chk("ones_settled", got[i], 8388607);
            fresh[0] = got[0];
            fresh[1] = got[1];
        end else begin
            chk("ones_got_size", got.size(), 16);
        end

        // All-zeros, random spacing
        clr_stats();
        for (int i = 0; i < 1024; i++) drive(1'b0, int'($urandom_range(0, 3)), sc);
        repeat (10) @(negedge clk);
        chk("zeros_pulse_count", pulses, 16);
        if (got.size() == 16) for (int i = 8; i < 16; i++) chk("zeros_settled", got[i], -8388608);

        // Alternating 1,0
        clr_stats();
        for (int i = 0; i < 1024; i++) drive(1'((i + 1) % 2), int'($urandom_range(0, 3)), sc);
        repeat (10) @(negedge clk);
        if (got.size() == 16) for (int i = 12; i < 16; i++) chk("alt_settled", got[i], 0);
        else chk("alt_got_size", got.size(), 16);

        // Back-to-back strobes
        clr_stats();
        for (int i = 0; i < 640; i++) drive(1'b1, 0, sc);
        repeat (10) @(negedge clk);
        chk("b2b_pulse_count", pulses, 10);
        chk("b2b_pulse_span", last_cyc - first_cyc, 9 * 64);
        if (got.size() == 10) chk("b2b_settled", got[9], 8388607);

        // Random data with random spacing
        clr_stats();
        for (int i = 0; i < 2048; i++) drive(1'($urandom), int'($urandom_range(0, 2)), sc);
        repeat (10) @(negedge clk);
        chk("rand_pulse_count", pulses, 32);

        // Mid-operation reset, then a run that must match the fresh all-ones start
        for (int i = 0; i < 100; i++) drive(1'($urandom), 1, sc);
        do_reset(3);
        chk("midrst_pcm_out", $signed(pcm_out), 0);
        clr_stats();
        for (int i = 0; i < 128; i++) begin
            drive(1'b1, 2, sc);
            if (i == 63) s64 = sc;
        end
        repeat (10) @(negedge clk);
        chk("midrst_first_latency", first_cyc, s64 + 3);
        chk("midrst_pulse_count", pulses, 2);
        if (got.size() == 2) begin
            chk("midrst_match_fresh0", got[0], fresh[0]);
            chk("midrst_match_fresh1", got[1], fresh[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
